// File: rtl/cpu_types_pkg.sv
// Shared CPU types: hazard-controller state, register-file constants and
// the bundle of per-stage latch controls driven by the hazard controller.
package cpu_types_pkg;

   // Hazard controller sequencing state
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      HALT  = 2'd2
   } hzstate_t;

   // Register zero is hard-wired; writes to it never create a dependency
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Per-cycle stage control bundle
   typedef struct packed {
      logic pc_en;
      logic if_en;
      logic id_en;
      logic ex_en;
      logic mem_en;
      logic if_flush;
      logic id_flush;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags when the load in ID/EX targets a register the
// instruction in IF/ID is about to read. Purely combinational so a future
// forwarding unit can share it.
module hazard_detect
   import cpu_types_pkg::*;
#(
   parameter bit LU_DETECT = 1'b1
) (
   input  logic       i_id_uses_rt,
   input  logic [4:0] i_id_rs,
   input  logic [4:0] i_id_rt,
   input  logic       i_ex_mem2reg,
   input  logic       i_ex_regwen,
   input  logic [4:0] i_ex_wsel,
   output logic       o_lu
);

   logic w_rs_match;
   logic w_rt_match;
   logic w_ex_load;

   assign w_rs_match = (i_ex_wsel == i_id_rs);
   assign w_rt_match = i_id_uses_rt & (i_ex_wsel == i_id_rt);
   assign w_ex_load  = i_ex_mem2reg & i_ex_regwen & (i_ex_wsel != REG_ZERO);

   assign o_lu = LU_DETECT & w_ex_load & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: resolves data-miss freeze, halt, redirect,
// load-use and fetch-miss each cycle into latch enables / bubble strobes,
// and keeps wrap-around performance counters.
module pipeline_hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter bit LU_DETECT = 1'b1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dmem_req,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem2reg,
   input  logic             ex_regwen,
   input  logic [4:0]       ex_wsel,
   input  logic             redirect,
   input  logic             mem_halt,
   output logic             pc_en,
   output logic             if_en,
   output logic             id_en,
   output logic             ex_en,
   output logic             mem_en,
   output logic             if_flush,
   output logic             id_flush,
   output logic             halted,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hzstate_t         r_state;
   hzstate_t         w_next_state;
   stage_ctrl_t      w_ctrl;
   logic             w_dmiss;
   logic             w_lu;
   logic             w_flush_fire;
   logic [CNT_W-1:0] r_cyc_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   assign w_dmiss = dmem_req & ~dhit;

   hazard_detect #(
      .LU_DETECT (LU_DETECT)
   ) u_hazard_detect (
      .i_id_uses_rt (id_uses_rt),
      .i_id_rs      (id_rs),
      .i_id_rt      (id_rt),
      .i_ex_mem2reg (ex_mem2reg),
      .i_ex_regwen  (ex_regwen),
      .i_ex_wsel    (ex_wsel),
      .o_lu         (w_lu)
   );

   // State register; a reset mid-freeze simply drops back to RUN
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= RUN;
      else       r_state <= w_next_state;
   end

   // Priority resolution of hazards into stage controls and next state
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_ctrl       = CTRL_NONE;
      w_next_state = r_state;
      w_flush_fire = 1'b0;
      case (r_state)
         RUN, DWAIT: begin
            if (w_dmiss) begin
               w_next_state = DWAIT;
            end else if (mem_halt) begin
               // Let the halt retire into WB, freeze everything upstream
               w_ctrl.mem_en = 1'b1;
               w_next_state  = HALT;
            end else if (redirect) begin
               // Squash the wrong-path fetch and decode; also covers any
               // coincident load-use or fetch miss
               w_ctrl       = '{pc_en: 1'b1, if_en: 1'b1, id_en: 1'b1,
                                ex_en: 1'b1, mem_en: 1'b1,
                                if_flush: 1'b1, id_flush: 1'b1};
               w_flush_fire = 1'b1;
               w_next_state = RUN;
            end else if (w_lu) begin
               // Hold PC and IF/ID, insert one bubble into ID/EX
               w_ctrl       = '{pc_en: 1'b0, if_en: 1'b0, id_en: 1'b1,
                                ex_en: 1'b1, mem_en: 1'b1,
                                if_flush: 1'b0, id_flush: 1'b1};
               w_next_state = RUN;
            end else if (!ihit) begin
               // No fetch word: bubble into IF/ID, drain the rest
               w_ctrl       = '{pc_en: 1'b0, if_en: 1'b1, id_en: 1'b1,
                                ex_en: 1'b1, mem_en: 1'b1,
                                if_flush: 1'b1, id_flush: 1'b0};
               w_next_state = RUN;
            end else begin
               w_ctrl       = '{pc_en: 1'b1, if_en: 1'b1, id_en: 1'b1,
                                ex_en: 1'b1, mem_en: 1'b1,
                                if_flush: 1'b0, id_flush: 1'b0};
               w_next_state = RUN;
            end
         end
         HALT: begin
            w_next_state = HALT;
         end
         default: begin
            w_next_state = RUN;
         end
      endcase
      // Reset forces every strobe low immediately, independent of the clock
      if (!nRST) begin
         w_ctrl       = CTRL_NONE;
         w_flush_fire = 1'b0;
      end
   end

   assign pc_en    = w_ctrl.pc_en;
   assign if_en    = w_ctrl.if_en;
   assign id_en    = w_ctrl.id_en;
   assign ex_en    = w_ctrl.ex_en;
   assign mem_en   = w_ctrl.mem_en;
   assign if_flush = w_ctrl.if_flush;
   assign id_flush = w_ctrl.id_flush;
   assign halted   = (r_state == HALT);

   // Wrap-around performance counters, frozen once halted
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_cyc_cnt   <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (r_state != HALT) begin
         r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
         if (!w_ctrl.pc_en) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush_fire)  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign cyc_cnt   = r_cyc_cnt;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances share stimulus, one with
// 32-bit counters and load-use detection, one with 4-bit counters and
// load-use detection disabled. A rule-table model predicts both.
module tb_pipeline_hazard_ctrl;
   import cpu_types_pkg::*;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dhit, dmem_req, id_uses_rt, ex_mem2reg, ex_regwen;
   logic       redirect, mem_halt;
   logic [4:0] id_rs, id_rt, ex_wsel;

   logic        pc_a, if_a, id_a, ex_a, mem_a, iff_a, idf_a, halted_a;
   logic [31:0] cyc_a, stall_a, flush_a;
   logic        pc_b, if_b, id_b, ex_b, mem_b, iff_b, idf_b, halted_b;
   logic [3:0]  cyc_b, stall_b, flush_b;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   pipeline_hazard_ctrl #(.CNT_W(32), .LU_DETECT(1'b1)) dut_a (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem2reg(ex_mem2reg), .ex_regwen(ex_regwen), .ex_wsel(ex_wsel),
      .redirect(redirect), .mem_halt(mem_halt),
      .pc_en(pc_a), .if_en(if_a), .id_en(id_a), .ex_en(ex_a), .mem_en(mem_a),
      .if_flush(iff_a), .id_flush(idf_a), .halted(halted_a),
      .cyc_cnt(cyc_a), .stall_cnt(stall_a), .flush_cnt(flush_a));

   pipeline_hazard_ctrl #(.CNT_W(4), .LU_DETECT(1'b0)) dut_b (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem2reg(ex_mem2reg), .ex_regwen(ex_regwen), .ex_wsel(ex_wsel),
      .redirect(redirect), .mem_halt(mem_halt),
      .pc_en(pc_b), .if_en(if_b), .id_en(id_b), .ex_en(ex_b), .mem_en(mem_b),
      .if_flush(iff_b), .id_flush(idf_b), .halted(halted_b),
      .cyc_cnt(cyc_b), .stall_cnt(stall_b), .flush_cnt(flush_b));

   // Expected controls per rule, packed {pc,if,id,ex,mem,if_flush,id_flush}.
   // Index 0 = halted (all quiet), 1..6 = priority rules.
   logic [6:0] rule_ctrl [7] = '{7'b0000000, 7'b0000000, 7'b0000100,
                                 7'b1111111, 7'b0011101, 7'b0111110,
                                 7'b1111100};

   // Model state per instance: halted flag, waiting-on-data flag, counters
   bit          m_halt  [2];
   bit          m_wait  [2];
   logic [31:0] m_cyc   [2];
   logic [31:0] m_stall [2];
   logic [31:0] m_flush [2];
   logic [31:0] m_mask  [2] = '{32'hFFFF_FFFF, 32'h0000_000F};
   bit          m_lu_on [2] = '{1'b1, 1'b0};

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick_rule(input int k);
      bit lu;
      lu = m_lu_on[k] && ex_mem2reg && ex_regwen && (ex_wsel != 0) &&
           ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
      if (m_halt[k])              return 0;
      if (dmem_req && !dhit)      return 1;
      if (mem_halt)               return 2;
      if (redirect)               return 3;
      if (lu)                     return 4;
      if (!ihit)                  return 5;
      return 6;
   endfunction

   function automatic logic [31:0] exp_state();
      if (m_halt[0]) return 32'(HALT);
      if (m_wait[0]) return 32'(DWAIT);
      return 32'(RUN);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_halt[k] = 0; m_wait[k] = 0;
         m_cyc[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end
   endtask

   task automatic set_idle();
      ihit = 1; dhit = 0; dmem_req = 0; id_uses_rt = 0; ex_mem2reg = 0;
      ex_regwen = 0; redirect = 0; mem_halt = 0;
      id_rs = 0; id_rt = 0; ex_wsel = 0;
   endtask

   // One clock: check combinational outputs, clock, advance model,
   // check registered results
   task automatic step(input string tag);
      int r [2];
      for (int k = 0; k < 2; k++) r[k] = pick_rule(k);
      #2;
      check({tag, "/ctrl_a"}, 32'({pc_a, if_a, id_a, ex_a, mem_a, iff_a, idf_a}),
            32'(rule_ctrl[r[0]]));
      check({tag, "/ctrl_b"}, 32'({pc_b, if_b, id_b, ex_b, mem_b, iff_b, idf_b}),
            32'(rule_ctrl[r[1]]));
      @(posedge CLK);
      for (int k = 0; k < 2; k++) begin
         if (!m_halt[k]) begin
            m_cyc[k] = (m_cyc[k] + 1) & m_mask[k];
            if (!rule_ctrl[r[k]][6]) m_stall[k] = (m_stall[k] + 1) & m_mask[k];
            if (r[k] == 3)           m_flush[k] = (m_flush[k] + 1) & m_mask[k];
            m_wait[k] = (r[k] == 1);
            if (r[k] == 2) m_halt[k] = 1;
         end
      end
      #1;
      check({tag, "/halted_a"}, 32'(halted_a), 32'(m_halt[0]));
      check({tag, "/halted_b"}, 32'(halted_b), 32'(m_halt[1]));
      check({tag, "/state_a"},  32'(dut_a.r_state), exp_state());
      check({tag, "/cyc_a"},    cyc_a,   m_cyc[0]);
      check({tag, "/stall_a"},  stall_a, m_stall[0]);
      check({tag, "/flush_a"},  flush_a, m_flush[0]);
      check({tag, "/cyc_b"},    32'(cyc_b),   m_cyc[1]);
      check({tag, "/stall_b"},  32'(stall_b), m_stall[1]);
      check({tag, "/flush_b"},  32'(flush_b), m_flush[1]);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "/ctrl_a"}, 32'({pc_a, if_a, id_a, ex_a, mem_a, iff_a, idf_a}), 0);
      check({tag, "/ctrl_b"}, 32'({pc_b, if_b, id_b, ex_b, mem_b, iff_b, idf_b}), 0);
      check({tag, "/cnt_a"},  cyc_a | stall_a | flush_a, 0);
      check({tag, "/halted"}, 32'({halted_a, halted_b}), 0);
   endtask

   task automatic release_reset();
      @(posedge CLK); #1;
      nRST = 1;
   endtask

   initial begin
      logic [31:0] s0, f0;

      // Reset state
      set_idle();
      nRST = 0;
      model_reset();
      #3;
      check_quiet("reset");
      release_reset();

      // 1: ten clean cycles
      for (int i = 0; i < 10; i++) step("idle");
      check("t1_cyc", cyc_a, 10);
      check("t1_stall", stall_a, 0);

      // 2: load-use on rs, then same with wsel=0
      s0 = stall_a;
      ex_mem2reg = 1; ex_regwen = 1; ex_wsel = 5; id_rs = 5;
      step("lu");
      check("t2_stall_delta", stall_a - s0, 1);
      ex_wsel = 0; id_rs = 0;
      step("lu_r0");
      check("t2_r0_nostall", stall_a - s0, 1);
      ex_wsel = 9; id_rt = 9; id_rs = 3; id_uses_rt = 1;
      step("lu_rt");
      set_idle();

      // 3: three miss cycles, then the hit
      s0 = stall_a;
      dmem_req = 1; dhit = 0;
      for (int i = 0; i < 3; i++) step("dmiss");
      dhit = 1;
      step("dhit");
      check("t3_stall_delta", stall_a - s0, 3);
      set_idle();

      // 4: redirect over fetch miss, then fetch miss alone
      f0 = flush_a;
      ihit = 0; redirect = 1;
      step("redir_imiss");
      check("t4_flush_delta", flush_a - f0, 1);
      redirect = 0;
      step("imiss");
      ihit = 1; redirect = 1; ex_mem2reg = 1; ex_regwen = 1; ex_wsel = 7; id_rs = 7;
      step("redir_lu");
      set_idle();

      // Randomized traffic (no halt)
      for (int i = 0; i < 400; i++) begin
         ihit       = ($urandom % 4) != 0;
         dmem_req   = ($urandom % 3) == 0;
         dhit       = $urandom % 2;
         id_rs      = 5'($urandom % 4);
         id_rt      = 5'($urandom % 4);
         id_uses_rt = $urandom % 2;
         ex_mem2reg = $urandom % 2;
         ex_regwen  = $urandom % 2;
         ex_wsel    = 5'($urandom % 4);
         redirect   = ($urandom % 6) == 0;
         mem_halt   = 0;
         step("rand");
      end
      set_idle();

      // 6: reset in the middle of a data-miss freeze
      dmem_req = 1; dhit = 0;
      step("pre_rst_miss");
      step("pre_rst_miss");
      nRST = 0;
      model_reset();
      #1;
      check_quiet("rst_in_dwait");
      check("rst_state", 32'(dut_a.r_state), 32'(RUN));
      set_idle();
      release_reset();
      for (int i = 0; i < 17; i++) step("wrap");
      check("t6_wrap_b", 32'(cyc_b), 1);
      check("t6_nowrap_a", cyc_a, 17);

      // 5: halt, then inputs toggle with no effect
      mem_halt = 1;
      step("halt");
      check("t5_halted", 32'(halted_a), 1);
      s0 = cyc_a;
      for (int i = 0; i < 6; i++) begin
         ihit       = $urandom % 2;
         redirect   = $urandom % 2;
         mem_halt   = $urandom % 2;
         dmem_req   = $urandom % 2;
         ex_mem2reg = 1; ex_regwen = 1; ex_wsel = 4; id_rs = 4;
         step("halted_hold");
      end
      check("t5_cyc_frozen", cyc_a, s0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog: the sequence is bounded, but never let the run hang
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
